// File: rtl/store_queue_if.sv
// Bundles every store-queue signal except clock and reset: the data-cache
// request side, the store-queue responses, and the write path to L2.
//
// L2 write handshake: the store queue raises l2_req_valid with
// strand/addr/data/mask stable. The request is transferred on any rising
// edge where l2_req_valid and l2_req_ready are both high. While valid is
// high and ready is low, every l2_req_* field stays unchanged. Ready may
// rise or fall freely and never depends on valid.
interface store_queue_if #(
  parameter int STRANDS    = 4,
  parameter int LINE_BYTES = 64
);
  localparam int SW = (STRANDS > 1) ? $clog2(STRANDS) : 1;
  localparam int DW = LINE_BYTES * 8;

  logic                  dcache_store;
  logic                  dcache_load;
  logic                  dcache_stbar;
  logic [SW-1:0]         dcache_req_strand;
  logic [25:0]           dcache_addr;
  logic [DW-1:0]         data_to_dcache;
  logic [LINE_BYTES-1:0] dcache_store_mask;

  logic                  sq_rollback;
  logic [STRANDS-1:0]    sq_wait_strands;
  logic [STRANDS-1:0]    sq_wake_strands;
  logic                  sq_fwd_valid;
  logic [DW-1:0]         sq_fwd_data;
  logic [LINE_BYTES-1:0] sq_fwd_mask;

  logic                  l2_req_valid;
  logic [SW-1:0]         l2_req_strand;
  logic [25:0]           l2_req_addr;
  logic [DW-1:0]         l2_req_data;
  logic [LINE_BYTES-1:0] l2_req_mask;
  logic                  l2_req_ready;
  logic                  l2_ack_valid;
  logic [SW-1:0]         l2_ack_strand;

  // Per-strand entry state, two bits per strand (strand 0 in the low bits).
  logic [2*STRANDS-1:0]  dbg_state;

  modport slave (
    input  dcache_store, dcache_load, dcache_stbar, dcache_req_strand,
           dcache_addr, data_to_dcache, dcache_store_mask,
           l2_req_ready, l2_ack_valid, l2_ack_strand,
    output sq_rollback, sq_wait_strands, sq_wake_strands,
           sq_fwd_valid, sq_fwd_data, sq_fwd_mask,
           l2_req_valid, l2_req_strand, l2_req_addr, l2_req_data, l2_req_mask,
           dbg_state
  );

  modport master (
    output dcache_store, dcache_load, dcache_stbar, dcache_req_strand,
           dcache_addr, data_to_dcache, dcache_store_mask,
           l2_req_ready, l2_ack_valid, l2_ack_strand,
    input  sq_rollback, sq_wait_strands, sq_wake_strands,
           sq_fwd_valid, sq_fwd_data, sq_fwd_mask,
           l2_req_valid, l2_req_strand, l2_req_addr, l2_req_data, l2_req_mask,
           dbg_state
  );
endinterface

// File: rtl/store_queue.sv
// Per-strand store queue: one outstanding store per hardware strand,
// round-robin drain to L2, strand suspension/wake on a full entry, and
// same-strand store-to-load forwarding.
module store_queue #(
  parameter int STRANDS    = 4,
  parameter int LINE_BYTES = 64
) (
  input logic          clk,
  input logic          reset,
  store_queue_if.slave bus
);
  localparam int SW = (STRANDS > 1) ? $clog2(STRANDS) : 1;
  localparam int DW = LINE_BYTES * 8;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] ISSUED  = 2'd2;

  logic [1:0]            st     [STRANDS];
  logic [25:0]           addr_r [STRANDS];
  logic [DW-1:0]         data_r [STRANDS];
  logic [LINE_BYTES-1:0] mask_r [STRANDS];

  logic [STRANDS-1:0] req_hit, ack_hit, refuse, pending;
  logic [STRANDS-1:0] wait_r, wake_r;
  logic               rollback_r;

  logic [SW-1:0] ptr, hold_idx, rr_idx, grant;
  logic          hold, rr_found, any_pending, handshake;

  logic                  fwd_hit;
  logic [DW-1:0]         fwd_data_c;
  logic [LINE_BYTES-1:0] fwd_mask_c;
  logic                  fwd_valid_r;
  logic [DW-1:0]         fwd_data_r;
  logic [LINE_BYTES-1:0] fwd_mask_r;

  // Per-strand decode of this cycle's request and ack against pre-edge state.
  always_comb begin
    req_hit = '0;
    ack_hit = '0;
    refuse  = '0;
    pending = '0;
    for (int s = 0; s < STRANDS; s++) begin
      req_hit[s] = (bus.dcache_req_strand == SW'(s));
      ack_hit[s] = bus.l2_ack_valid && (bus.l2_ack_strand == SW'(s)) && (st[s] == ISSUED);
      refuse[s]  = req_hit[s] && (bus.dcache_store || bus.dcache_stbar) && (st[s] != EMPTY);
      pending[s] = (st[s] == PENDING);
    end
  end

  // Round-robin search over PENDING entries, starting after the last grant.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= STRANDS; i++) begin
      if (!rr_found && pending[SW'((int'(ptr) + i) % STRANDS)]) begin
        rr_found = 1'b1;
        rr_idx   = SW'((int'(ptr) + i) % STRANDS);
      end
    end
  end

  // A stalled request keeps its grant so the L2 bus stays stable.
  always_comb begin
    any_pending = |pending;
    grant       = hold ? hold_idx : rr_idx;
    handshake   = any_pending && bus.l2_req_ready;
  end

  // Forward lookup restricted to the requesting strand's own entry.
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data_c = '0;
    fwd_mask_c = '0;
    for (int s = 0; s < STRANDS; s++) begin
      if (bus.dcache_load && req_hit[s] && (st[s] != EMPTY) && (addr_r[s] == bus.dcache_addr)) begin
        fwd_hit    = 1'b1;
        fwd_data_c = data_r[s];
        fwd_mask_c = mask_r[s];
      end
    end
  end

  // Entry state machine: ack drains, handshake issues, store fills.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STRANDS; s++) begin
      if (reset) begin
        st[s] <= EMPTY;
      end else if (ack_hit[s]) begin
        st[s] <= EMPTY;
      end else if (handshake && (grant == SW'(s))) begin
        st[s] <= ISSUED;
      end else if (bus.dcache_store && req_hit[s] && (st[s] == EMPTY)) begin
        st[s] <= PENDING;
      end
    end
  end

  // Entry payload capture; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STRANDS; s++) begin
      if (!reset && bus.dcache_store && req_hit[s] && (st[s] == EMPTY)) begin
        addr_r[s] <= bus.dcache_addr;
        data_r[s] <= bus.data_to_dcache;
        mask_r[s] <= bus.dcache_store_mask;
      end
    end
  end

  // Arbitration pointer, grant hold, rollback and wait/wake bookkeeping.
  // A strand refused in the same cycle its entry drains is woken at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      hold       <= 1'b0;
      hold_idx   <= '0;
      rollback_r <= 1'b0;
      wait_r     <= '0;
      wake_r     <= '0;
    end else begin
      hold       <= any_pending && !bus.l2_req_ready;
      hold_idx   <= grant;
      rollback_r <= |refuse;
      if (handshake) ptr <= grant;
      for (int s = 0; s < STRANDS; s++) begin
        wake_r[s] <= ack_hit[s] && (wait_r[s] || refuse[s]);
        wait_r[s] <= ack_hit[s] ? 1'b0 : (wait_r[s] || refuse[s]);
      end
    end
  end

  // Registered forward result for last cycle's load.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_r <= 1'b0;
      fwd_data_r  <= '0;
      fwd_mask_r  <= '0;
    end else begin
      fwd_valid_r <= fwd_hit;
      fwd_data_r  <= fwd_data_c;
      fwd_mask_r  <= fwd_mask_c;
    end
  end

  // Output drive; L2 fields read as zero whenever nothing is requested.
  always_comb begin
    bus.sq_rollback     = rollback_r;
    bus.sq_wait_strands = wait_r;
    bus.sq_wake_strands = wake_r;
    bus.sq_fwd_valid    = fwd_valid_r;
    bus.sq_fwd_data     = fwd_data_r;
    bus.sq_fwd_mask     = fwd_mask_r;
    bus.l2_req_valid    = any_pending;
    bus.l2_req_strand   = any_pending ? grant : '0;
    bus.l2_req_addr     = any_pending ? addr_r[grant] : '0;
    bus.l2_req_data     = any_pending ? data_r[grant] : '0;
    bus.l2_req_mask     = any_pending ? mask_r[grant] : '0;
    bus.dbg_state       = '0;
    for (int s = 0; s < STRANDS; s++) begin
      bus.dbg_state[2*s +: 2] = st[s];
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the entry rules.
module tb_store_queue;
  localparam int S  = 4;
  localparam int LB = 64;
  localparam int DW = LB * 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;

  store_queue_if #(.STRANDS(S), .LINE_BYTES(LB)) bus ();

  store_queue #(.STRANDS(S), .LINE_BYTES(LB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard types ----------------
  typedef struct packed {
    logic          rb;
    logic [S-1:0]  wt;
    logic [S-1:0]  wk;
    logic          fv;
    logic [DW-1:0] fd;
    logic [LB-1:0] fm;
    logic          lv;
    logic [SW-1:0] ls;
    logic [25:0]   la;
    logic [DW-1:0] ld;
    logic [LB-1:0] lm;
    logic [2*S-1:0] st;
  } exp_t;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [25:0]   a;
    logic [DW-1:0] d;
    logic [LB-1:0] m;
  } txn_t;

  exp_t exp_q[$];
  txn_t l2_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;
  bit   full_mask = 1'b1;

  // ---------------- reference model ----------------
  // Entry states: 0 empty, 1 waiting to be sent, 2 sent awaiting ack.
  int            m_st   [S];
  logic [25:0]   m_addr [S];
  logic [DW-1:0] m_data [S];
  logic [LB-1:0] m_mask [S];
  bit            m_wait [S];
  int            m_last  = 0;
  bit            m_locked = 1'b0;
  int            m_grant = 0;
  exp_t          m_out   = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  // Applies the spec rules to the stimulus now on the bus and predicts
  // what the DUT presents after the coming edge.
  task automatic model_step();
    int   rs, ak, c;
    int   nst [S];
    bit   hs, refused, any, found;
    exp_t e;
    txn_t t;
    rs = int'(bus.dcache_req_strand);
    ak = int'(bus.l2_ack_strand);
    hs = m_out.lv && bus.l2_req_ready;
    if (hs) begin
      t.s = SW'(m_grant);
      t.a = m_addr[m_grant];
      t.d = m_data[m_grant];
      t.m = m_mask[m_grant];
      l2_q.push_back(t);
    end
    e = '0;
    if (reset) begin
      for (int s = 0; s < S; s++) begin
        m_st[s]   = 0;
        m_wait[s] = 1'b0;
      end
      m_last   = 0;
      m_locked = 1'b0;
    end else begin
      refused = (bus.dcache_store || bus.dcache_stbar) && (m_st[rs] != 0);
      e.rb = refused;
      if (refused) m_wait[rs] = 1'b1;
      if (bus.dcache_load && m_st[rs] != 0 && m_addr[rs] == bus.dcache_addr) begin
        e.fv = 1'b1;
        e.fd = m_data[rs];
        e.fm = m_mask[rs];
      end
      nst = m_st;
      if (bus.l2_ack_valid && m_st[ak] == 2) begin
        nst[ak] = 0;
        e.wk[ak] = m_wait[ak];
        m_wait[ak] = 1'b0;
      end
      if (hs) begin
        nst[m_grant] = 2;
        m_last = m_grant;
      end
      if (bus.dcache_store && m_st[rs] == 0) begin
        nst[rs]    = 1;
        m_addr[rs] = bus.dcache_addr;
        m_data[rs] = bus.data_to_dcache;
        m_mask[rs] = bus.dcache_store_mask;
      end
      m_st = nst;
      m_locked = m_out.lv && !bus.l2_req_ready;
    end
    any = 1'b0;
    for (int s = 0; s < S; s++) if (m_st[s] == 1) any = 1'b1;
    if (!m_locked) begin
      found = 1'b0;
      for (int i = 1; i <= S; i++) begin
        c = (m_last + i) % S;
        if (!found && m_st[c] == 1) begin
          found = 1'b1;
          m_grant = c;
        end
      end
    end
    e.lv = any;
    if (any) begin
      e.ls = SW'(m_grant);
      e.la = m_addr[m_grant];
      e.ld = m_data[m_grant];
      e.lm = m_mask[m_grant];
    end
    for (int s = 0; s < S; s++) begin
      e.wt[s] = m_wait[s];
      e.st[2*s +: 2] = 2'(m_st[s]);
    end
    m_out = e;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LB-1:0] rand_mask();
    logic [LB-1:0] v;
    for (int i = 0; i < LB; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // op: 0 idle, 1 store, 2 load, 3 stbar
  task automatic cyc(input int op, input int s, input logic [25:0] a, input bit ackv, input int acks);
    bus.dcache_store      = (op == 1);
    bus.dcache_load       = (op == 2);
    bus.dcache_stbar      = (op == 3);
    bus.dcache_req_strand = SW'(s);
    bus.dcache_addr       = a;
    bus.data_to_dcache    = rand_line();
    bus.dcache_store_mask = full_mask ? '1 : rand_mask();
    bus.l2_ack_valid      = ackv;
    bus.l2_ack_strand     = SW'(acks);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 26'h0, 1'b0, 0);
  endtask

  task automatic ack(input int s);
    cyc(0, 0, 26'h0, 1'b1, s);
  endtask

  // ---------------- monitors ----------------
  // Status outputs, once per cycle just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sq_rollback",     DW'(bus.sq_rollback),     DW'(e.rb));
        chk("sq_wait_strands", DW'(bus.sq_wait_strands), DW'(e.wt));
        chk("sq_wake_strands", DW'(bus.sq_wake_strands), DW'(e.wk));
        chk("sq_fwd_valid",    DW'(bus.sq_fwd_valid),    DW'(e.fv));
        chk("sq_fwd_data",     bus.sq_fwd_data,          e.fd);
        chk("sq_fwd_mask",     DW'(bus.sq_fwd_mask),     DW'(e.fm));
        chk("l2_req_valid",    DW'(bus.l2_req_valid),    DW'(e.lv));
        chk("l2_req_strand",   DW'(bus.l2_req_strand),   DW'(e.ls));
        chk("l2_req_addr",     DW'(bus.l2_req_addr),     DW'(e.la));
        chk("l2_req_data",     bus.l2_req_data,          e.ld);
        chk("l2_req_mask",     DW'(bus.l2_req_mask),     DW'(e.lm));
        chk("entry_state",     DW'(bus.dbg_state),       DW'(e.st));
      end
    end
  end

  // L2 transfers, checked mid-cycle while inputs and outputs are stable.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (bus.l2_req_valid === 1'b1 && bus.l2_req_ready === 1'b1) begin
        if (l2_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL l2_txn_unexpected (cycle %0d): got strand %0d addr %0h, expected no transfer",
                   cyc_no, bus.l2_req_strand, bus.l2_req_addr);
        end else begin
          t = l2_q.pop_front();
          chk("l2_txn_strand", DW'(bus.l2_req_strand), DW'(t.s));
          chk("l2_txn_addr",   DW'(bus.l2_req_addr),   DW'(t.a));
          chk("l2_txn_data",   bus.l2_req_data,        t.d);
          chk("l2_txn_mask",   DW'(bus.l2_req_mask),   DW'(t.m));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [25:0] pick [4];
    pick[0] = 26'h0000040;
    pick[1] = 26'h0000041;
    pick[2] = 26'h0000123;
    pick[3] = 26'h3FFFFFF;

    reset = 1'b1;
    bus.l2_req_ready = 1'b0;
    idle();
    idle();
    reset = 1'b0;

    // Single store drains and is acked; strand never waited, so no wake.
    bus.l2_req_ready = 1'b1;
    cyc(1, 1, 26'h0000123, 1'b0, 0);
    idle(); idle(); idle();
    ack(1);
    idle();

    // Back-to-back stores on strand 2: second refused, strand woken on ack.
    bus.l2_req_ready = 1'b0;
    cyc(1, 2, 26'h0000200, 1'b0, 0);
    cyc(1, 2, 26'h0000201, 1'b0, 0);
    idle();
    bus.l2_req_ready = 1'b1;
    idle(); idle();
    ack(2);
    cyc(1, 2, 26'h0000202, 1'b0, 0);
    idle(); idle();
    ack(2);
    idle();

    // Round-robin order 0,1,3 with the request held while stalled.
    bus.l2_req_ready = 1'b0;
    full_mask = 1'b0;
    cyc(1, 0, 26'h0000010, 1'b0, 0);
    cyc(1, 1, 26'h0000011, 1'b0, 0);
    cyc(1, 3, 26'h0000013, 1'b0, 0);
    idle(); idle(); idle();
    bus.l2_req_ready = 1'b1;
    idle(); idle(); idle(); idle();
    ack(0); ack(1); ack(3);
    idle();

    // Forwarding: hit on equal address, miss on neighbour and other strand.
    bus.l2_req_ready = 1'b0;
    cyc(1, 0, 26'h0000040, 1'b0, 0);
    cyc(2, 0, 26'h0000040, 1'b0, 0);
    cyc(2, 0, 26'h0000041, 1'b0, 0);
    cyc(2, 1, 26'h0000040, 1'b0, 0);
    bus.l2_req_ready = 1'b1;
    idle(); idle();
    cyc(2, 0, 26'h0000040, 1'b0, 0);
    ack(0);
    cyc(2, 0, 26'h0000040, 1'b0, 0);
    idle();

    // Store barrier: no-op when empty, refused while the entry is issued.
    cyc(3, 3, 26'h0, 1'b0, 0);
    cyc(1, 3, 26'h0000300, 1'b0, 0);
    idle(); idle();
    cyc(3, 3, 26'h0, 1'b0, 0);
    idle();
    ack(3);
    idle();

    // Reset with two pending entries and a waiter; a late ack is ignored.
    bus.l2_req_ready = 1'b0;
    cyc(1, 0, 26'h0000400, 1'b0, 0);
    cyc(1, 1, 26'h0000401, 1'b0, 0);
    cyc(1, 1, 26'h0000402, 1'b0, 0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    ack(0);
    ack(1);
    idle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int  op, s, ak;
      bit  av;
      op = $urandom_range(0, 3);
      s  = $urandom_range(0, S - 1);
      ak = $urandom_range(0, S - 1);
      av = ($urandom_range(0, 2) == 0);
      bus.l2_req_ready = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      cyc(op, s, pick[$urandom_range(0, 3)], av, ak);
    end
    reset = 1'b0;
    bus.l2_req_ready = 1'b1;
    for (int s = 0; s < S; s++) begin
      idle();
      ack(s);
    end
    idle();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL status_queue_drain: got %0d left expected 0", exp_q.size());
    end
    n_checks++;
    if (l2_q.size() != 0) begin
      n_fail++;
      $display("FAIL l2_txn_missing: got %0d transfers outstanding expected 0", l2_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
